iq_dac_spi: RTL and testbench

- Downstream consumer of the modulator's `mod_iq` output.
- Latches one I/Q sample per strobe and converts both 16-bit signed words to offset binary.
- Serialises the sample as two 24-bit SPI frames (command + data) to a dual-channel 16-bit DAC.
- Pulses LDAC so both channels update simultaneously. This gives the modulated baseband/IF its physical output path.

---
 rtl/iq_dac_spi_if.sv | 23 ++
 rtl/iq_dac_spi.sv | 122 ++++++++++++
 tb/tb_iq_dac_spi.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/iq_dac_spi_if.sv
// rtl/iq_dac_spi_if.sv - Sample input and DAC SPI output bundle for iq_dac_spi.
interface iq_dac_spi_if;
    logic [31:0] mod_iq;
    logic        iq_valid;
    logic        enable;
    logic        clr_overrun;
    logic        dac_sclk;
    logic        dac_mosi;
    logic        dac_cs_n;
    logic        dac_ldac_n;
    logic        busy;
    logic        overrun;

    modport master (
        output mod_iq, iq_valid, enable, clr_overrun,
        input  dac_sclk, dac_mosi, dac_cs_n, dac_ldac_n, busy, overrun
    );

    modport slave (
        input  mod_iq, iq_valid, enable, clr_overrun,
        output dac_sclk, dac_mosi, dac_cs_n, dac_ldac_n, busy, overrun
    );
endinterface

// File: rtl/iq_dac_spi.sv
// rtl/iq_dac_spi.sv - Latches I/Q samples and ships them as two 24-bit SPI frames plus an LDAC pulse.
module iq_dac_spi #(
    parameter int          CLK_DIV    = 2,
    parameter logic [7:0]  CMD_I      = 8'h18,
    parameter logic [7:0]  CMD_Q      = 8'h19,
    parameter int          CS_GAP     = 2,
    parameter int          LDAC_WIDTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    iq_dac_spi_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, FRAME_I, GAP_I, FRAME_Q, GAP_Q, LDAC} state_t;

    localparam logic [15:0] DIV_END  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_END  = 16'(CS_GAP - 1);
    localparam logic [15:0] LDAC_END = 16'(LDAC_WIDTH - 1);

    state_t      state;
    logic [23:0] shift;
    logic [15:0] q_reg;
    logic [15:0] cnt;
    logic [4:0]  bit_cnt;
    logic        sclk, mosi, cs_n, ldac_n, busy, overrun;

    assign bus.dac_sclk   = sclk;
    assign bus.dac_mosi   = mosi;
    assign bus.dac_cs_n   = cs_n;
    assign bus.dac_ldac_n = ldac_n;
    assign bus.busy       = busy;
    assign bus.overrun    = overrun;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift   <= '0;
            q_reg   <= '0;
            cnt     <= '0;
            bit_cnt <= '0;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            ldac_n  <= 1'b1;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            // Set has priority over clear so a drop is never lost.
            if (bus.iq_valid && busy)
                overrun <= 1'b1;
            else if (bus.clr_overrun)
                overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.iq_valid && bus.enable) begin
                        shift   <= {CMD_I, bus.mod_iq[31:16] ^ 16'h8000};
                        q_reg   <= bus.mod_iq[15:0] ^ 16'h8000;
                        mosi    <= CMD_I[7];
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        cnt     <= '0;
                        bit_cnt <= 5'd23;
                        state   <= FRAME_I;
                    end
                end
                FRAME_I, FRAME_Q: begin
                    if (cnt == DIV_END) begin
                        cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            sclk <= 1'b0;
                            if (bit_cnt == 5'd0) begin
                                cs_n  <= 1'b1;
                                state <= (state == FRAME_I) ? GAP_I : GAP_Q;
                            end else begin
                                // Next bit goes out at the start of its low phase.
                                bit_cnt <= bit_cnt - 5'd1;
                                shift   <= {shift[22:0], 1'b0};
                                mosi    <= shift[22];
                            end
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP_I: begin
                    if (cnt == GAP_END) begin
                        cnt     <= '0;
                        shift   <= {CMD_Q, q_reg};
                        mosi    <= CMD_Q[7];
                        cs_n    <= 1'b0;
                        bit_cnt <= 5'd23;
                        state   <= FRAME_Q;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP_Q: begin
                    if (cnt == GAP_END) begin
                        cnt    <= '0;
                        ldac_n <= 1'b0;
                        state  <= LDAC;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                LDAC: begin
                    if (cnt == LDAC_END) begin
                        cnt    <= '0;
                        ldac_n <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iq_dac_spi.sv
// tb/tb_iq_dac_spi.sv - Self-checking bench for iq_dac_spi against a frame-level reference model.
module tb_iq_dac_spi;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    iq_dac_spi_if bus_if();
    iq_dac_spi dut (.clk(clk), .rst(rst), .bus(bus_if.slave));

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] frames_q[$];
    int len_q[$], edge_q[$], gap_q[$], ldac_q[$], busy_q[$];
    int stable_err = 0;

    logic p_sclk = 1'b0, p_mosi = 1'b0, p_cs = 1'b1, p_ldac = 1'b1, p_busy = 1'b0;
    logic [23:0] cur_bits = '0;
    int cur_len = 0, cur_edges = 0, hi_run = 0, ldac_run = 0, busy_run = 0;

    // Bus observer: rebuilds frames, pulse widths and run lengths from the pins.
    always @(posedge clk) begin
        #2;
        if (bus_if.dac_cs_n === 1'b0) begin
            if (p_cs) begin
                cur_bits = '0; cur_len = 0; cur_edges = 0;
                if (p_busy) gap_q.push_back(hi_run);
            end
            cur_len++;
            if (bus_if.dac_sclk && !p_sclk) begin
                cur_bits = {cur_bits[22:0], bus_if.dac_mosi};
                cur_edges++;
                if (bus_if.dac_mosi !== p_mosi) stable_err++;
            end else if (bus_if.dac_sclk && p_sclk && bus_if.dac_mosi !== p_mosi) begin
                stable_err++;
            end
        end else begin
            if (!p_cs) begin
                frames_q.push_back(cur_bits);
                len_q.push_back(cur_len);
                edge_q.push_back(cur_edges);
                hi_run = 0;
            end
            hi_run++;
        end
        if (bus_if.dac_ldac_n === 1'b0) ldac_run = p_ldac ? 1 : ldac_run + 1;
        else if (!p_ldac) ldac_q.push_back(ldac_run);
        if (bus_if.busy === 1'b1) busy_run = p_busy ? busy_run + 1 : 1;
        else if (p_busy) busy_q.push_back(busy_run);
        p_sclk = bus_if.dac_sclk; p_mosi = bus_if.dac_mosi; p_cs = bus_if.dac_cs_n;
        p_ldac = bus_if.dac_ldac_n; p_busy = bus_if.busy;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model_frame(input logic [7:0] cmd, input logic signed [15:0] v);
        logic [31:0] off;
        off = 32'(int'(v) + 32768);
        return {cmd, off[15:0]};
    endfunction

    task automatic clear_mon();
        frames_q.delete(); len_q.delete(); edge_q.delete(); gap_q.delete();
        ldac_q.delete(); busy_q.delete(); stable_err = 0;
    endtask

    task automatic send(input logic [31:0] iq);
        @(negedge clk);
        bus_if.mod_iq = iq; bus_if.iq_valid = 1'b1; bus_if.enable = 1'b1;
        @(negedge clk);
        bus_if.iq_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus_if.busy !== 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        chk("idle_wait", 32'(bus_if.busy), 32'd0);
    endtask

    task automatic check_txn(input string tag, input logic [31:0] iq, input int base);
        int t = base / 2;
        chk({tag, "_nframes_ge"}, 32'(frames_q.size() >= base + 2), 32'd1);
        if (frames_q.size() >= base + 2) begin
            chk({tag, "_frame_i"}, 32'(frames_q[base]), 32'(model_frame(8'h18, iq[31:16])));
            chk({tag, "_frame_q"}, 32'(frames_q[base + 1]), 32'(model_frame(8'h19, iq[15:0])));
            chk({tag, "_len_i"}, len_q[base], 32'd96);
            chk({tag, "_len_q"}, len_q[base + 1], 32'd96);
            chk({tag, "_edges_i"}, edge_q[base], 32'd24);
            chk({tag, "_edges_q"}, edge_q[base + 1], 32'd24);
        end
        chk({tag, "_ngap_gt"}, 32'(gap_q.size() > t), 32'd1);
        if (gap_q.size() > t) chk({tag, "_gap"}, gap_q[t], 32'd2);
        chk({tag, "_nldac_gt"}, 32'(ldac_q.size() > t), 32'd1);
        if (ldac_q.size() > t) chk({tag, "_ldac"}, ldac_q[t], 32'd2);
        chk({tag, "_nbusy_gt"}, 32'(busy_q.size() > t), 32'd1);
        if (busy_q.size() > t) chk({tag, "_busy_len"}, busy_q[t], 32'd198);
        chk({tag, "_mosi_stable"}, stable_err, 32'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        rst = 1'b1;
        bus_if.mod_iq = '0; bus_if.iq_valid = 1'b0; bus_if.enable = 1'b1; bus_if.clr_overrun = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sclk", 32'(bus_if.dac_sclk), 32'd0);
        chk("rst_mosi", 32'(bus_if.dac_mosi), 32'd0);
        chk("rst_cs_n", 32'(bus_if.dac_cs_n), 32'd1);
        chk("rst_ldac_n", 32'(bus_if.dac_ldac_n), 32'd1);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_overrun", 32'(bus_if.overrun), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        clear_mon();

        send(32'h7FFF_8000); wait_idle();
        check_txn("full_scale", 32'h7FFF_8000, 0);
        chk("full_scale_i_bits", 32'(frames_q[0]), 32'h18FFFF);
        chk("full_scale_q_bits", 32'(frames_q[1]), 32'h190000);
        @(negedge clk); clear_mon();

        send(32'h0000_FFFF); wait_idle();
        check_txn("mid_scale", 32'h0000_FFFF, 0);
        @(negedge clk); clear_mon();

        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            send(a); wait_idle();
            check_txn($sformatf("rand%0d", i), a, 0);
            @(negedge clk); clear_mon();
        end

        a = $urandom; b = ~a;
        send(a);
        repeat (48) @(negedge clk);
        bus_if.mod_iq = b; bus_if.iq_valid = 1'b1;
        @(negedge clk); bus_if.iq_valid = 1'b0;
        chk("overrun_set", 32'(bus_if.overrun), 32'd1);
        repeat (10) @(negedge clk);
        bus_if.iq_valid = 1'b1; bus_if.clr_overrun = 1'b1;
        @(negedge clk); bus_if.iq_valid = 1'b0; bus_if.clr_overrun = 1'b0;
        chk("overrun_set_wins", 32'(bus_if.overrun), 32'd1);
        wait_idle();
        check_txn("overrun_first", a, 0);
        chk("overrun_nframes", frames_q.size(), 32'd2);
        bus_if.clr_overrun = 1'b1;
        @(negedge clk); bus_if.clr_overrun = 1'b0;
        chk("overrun_cleared", 32'(bus_if.overrun), 32'd0);
        @(negedge clk); clear_mon();

        a = $urandom; b = $urandom;
        send(a); wait_idle();
        bus_if.mod_iq = b; bus_if.iq_valid = 1'b1;
        @(negedge clk); bus_if.iq_valid = 1'b0;
        chk("b2b_cs_fall", 32'(bus_if.dac_cs_n), 32'd0);
        chk("b2b_busy", 32'(bus_if.busy), 32'd1);
        wait_idle();
        check_txn("b2b_first", a, 0);
        check_txn("b2b_second", b, 2);
        chk("b2b_overrun", 32'(bus_if.overrun), 32'd0);
        @(negedge clk); clear_mon();

        bus_if.enable = 1'b0; bus_if.mod_iq = $urandom; bus_if.iq_valid = 1'b1;
        @(negedge clk); bus_if.iq_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("gate_nframes", frames_q.size(), 32'd0);
        chk("gate_cs_n", 32'(bus_if.dac_cs_n), 32'd1);
        chk("gate_busy", 32'(bus_if.busy), 32'd0);
        chk("gate_overrun", 32'(bus_if.overrun), 32'd0);
        clear_mon();

        a = $urandom;
        send(a);
        repeat (110) @(negedge clk);
        bus_if.enable = 1'b0;
        wait_idle();
        check_txn("enable_drop", a, 0);
        bus_if.enable = 1'b1;
        @(negedge clk); clear_mon();

        a = $urandom; b = $urandom;
        send(a);
        repeat (52) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_cs_n", 32'(bus_if.dac_cs_n), 32'd1);
        chk("abort_sclk", 32'(bus_if.dac_sclk), 32'd0);
        chk("abort_ldac_n", 32'(bus_if.dac_ldac_n), 32'd1);
        chk("abort_busy", 32'(bus_if.busy), 32'd0);
        @(negedge clk); clear_mon();
        repeat (250) @(negedge clk);
        chk("abort_no_ldac", ldac_q.size(), 32'd0);
        chk("abort_no_frames", frames_q.size(), 32'd0);
        send(b); wait_idle();
        check_txn("after_abort", b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
